// File: rtl/uart_piso_framer.sv
// uart_piso_framer: UART transmit framer with one-deep holding register and back-to-back frames
module uart_piso_framer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 serial_data_tx,
  output logic                 active_flag,
  output logic                 done_flag,
  output logic                 overrun_flag
);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state;
  logic [DATA_BITS-1:0] sh, hold_data, frame_data;
  logic [3:0] cnt;
  logic par_bit, hold_par, hold_full, frame_par, calc_par;
  logic accept, last_stop, idle_accept, begin_frame;
  function automatic logic [DATA_BITS-1:0] order(input logic [DATA_BITS-1:0] d);
    for (int i = 0; i < DATA_BITS; i++) order[i] = (LSB_FIRST != 0) ? d[i] : d[DATA_BITS-1-i];
  endfunction
  assign tx_ready    = !hold_full;
  assign active_flag = state != IDLE;
  assign accept      = tx_start && tx_ready;
  assign last_stop   = state == STOP && cnt == 4'(STOP_BITS - 1);
  // an accept on the final stop edge can only happen with the holding register empty
  assign idle_accept = accept && (state == IDLE || last_stop);
  assign begin_frame = idle_accept || (last_stop && hold_full);
  assign calc_par    = ^tx_data ^ (PARITY == 2);
  assign frame_data  = hold_full ? hold_data : tx_data;
  assign frame_par   = hold_full ? hold_par : calc_par;
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state          <= IDLE;
      serial_data_tx <= 1'b1;
      done_flag      <= 1'b0;
      overrun_flag   <= 1'b0;
      hold_full      <= 1'b0;
      hold_data      <= '0;
      hold_par       <= 1'b0;
      sh             <= '0;
      par_bit        <= 1'b0;
      cnt            <= '0;
    end else begin
      done_flag    <= last_stop;
      overrun_flag <= tx_start && !tx_ready;
      if (last_stop && hold_full) hold_full <= 1'b0;
      if (accept && !idle_accept) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
        hold_par  <= calc_par;
      end
      if (begin_frame) begin
        state          <= START;
        serial_data_tx <= 1'b0;
        sh             <= order(frame_data);
        par_bit        <= frame_par;
        cnt            <= '0;
      end else begin
        case (state)
          START: begin
            state          <= DATA;
            serial_data_tx <= sh[0];
            sh             <= sh >> 1;
            cnt            <= '0;
          end
          DATA: begin
            if (cnt == 4'(DATA_BITS - 1)) begin
              state          <= (PARITY != 0) ? PAR : STOP;
              serial_data_tx <= (PARITY != 0) ? par_bit : 1'b1;
              cnt            <= '0;
            end else begin
              serial_data_tx <= sh[0];
              sh             <= sh >> 1;
              cnt            <= cnt + 4'd1;
            end
          end
          PAR: begin
            state          <= STOP;
            serial_data_tx <= 1'b1;
            cnt            <= '0;
          end
          STOP: begin
            state          <= last_stop ? IDLE : STOP;
            serial_data_tx <= 1'b1;
            cnt            <= last_stop ? 4'd0 : cnt + 4'd1;
          end
          default: begin
            state          <= IDLE;
            serial_data_tx <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule
